// File: rtl/datapath_seq.sv
// Self-sequencing RISC datapath: register file, A/B/C pipeline registers, shifter, ALU and
// writeback mux, with commands run through read, execute and writeback phases.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RW-1:0]    cmd_rda,
  input  logic [RW-1:0]    cmd_rdb,
  input  logic [RW-1:0]    cmd_wrn,
  input  logic             cmd_write,
  input  logic [1:0]       cmd_vsel,
  input  logic [1:0]       cmd_shift,
  input  logic [1:0]       cmd_aluop,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic             cmd_loads,
  input  logic [WIDTH-1:0] mdata,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] pc,
  output logic             done,
  output logic [2:0]       status,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  input  logic [RW-1:0]    dbg_num,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] A;

  logic [RW-1:0]    l_rda, l_rdb, l_wrn;
  logic             l_write, l_asel, l_bsel, l_loads;
  logic [1:0]       l_vsel, l_shift, l_aluop;
  logic [WIDTH-1:0] l_mdata, l_sximm5, l_sximm8, l_pc;

  logic             accept;
  logic [WIDTH-1:0] ain, bsh, bin, alu_res, wb_data;
  logic             alu_v;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && (state == S_IDLE);
  assign done      = (state == S_WB);
  assign dbg_data  = regs[dbg_num];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (cmd_vsel == 2'b00) ? S_RDA : S_WB;
      S_RDA:  state_nx = S_RDB;
      S_RDB:  state_nx = S_EXEC;
      S_EXEC: state_nx = S_WB;
      S_WB:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Overflow: add wraps when same-sign operands give a differently signed result;
  // sub wraps when opposite-sign operands do.
  always_comb begin
    ain = l_asel ? '0 : A;
    case (l_shift)
      2'b01:   bsh = {B[WIDTH-2:0], 1'b0};
      2'b10:   bsh = {1'b0, B[WIDTH-1:1]};
      2'b11:   bsh = {B[WIDTH-1], B[WIDTH-1:1]};
      default: bsh = B;
    endcase
    bin   = l_bsel ? l_sximm5 : bsh;
    alu_v = 1'b0;
    case (l_aluop)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
    case (l_vsel)
      2'b00:   wb_data = C;
      2'b01:   wb_data = l_mdata;
      2'b10:   wb_data = l_sximm8;
      default: wb_data = l_pc;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      A        <= '0;
      B        <= '0;
      C        <= '0;
      status   <= '0;
      l_rda    <= '0;
      l_rdb    <= '0;
      l_wrn    <= '0;
      l_write  <= 1'b0;
      l_vsel   <= '0;
      l_shift  <= '0;
      l_aluop  <= '0;
      l_asel   <= 1'b0;
      l_bsel   <= 1'b0;
      l_loads  <= 1'b0;
      l_mdata  <= '0;
      l_sximm5 <= '0;
      l_sximm8 <= '0;
      l_pc     <= '0;
    end else begin
      if (accept) begin
        l_rda    <= cmd_rda;
        l_rdb    <= cmd_rdb;
        l_wrn    <= cmd_wrn;
        l_write  <= cmd_write;
        l_vsel   <= cmd_vsel;
        l_shift  <= cmd_shift;
        l_aluop  <= cmd_aluop;
        l_asel   <= cmd_asel;
        l_bsel   <= cmd_bsel;
        l_loads  <= cmd_loads;
        l_mdata  <= mdata;
        l_sximm5 <= sximm5;
        l_sximm8 <= sximm8;
        l_pc     <= pc;
      end
      case (state)
        S_RDA:  A <= regs[l_rda];
        S_RDB:  B <= regs[l_rdb];
        S_EXEC: begin
          C <= alu_res;
          if (l_loads) status <= {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
        end
        S_WB:   if (l_write) regs[l_wrn] <= wb_data;
        default: ;
      endcase
    end
  end

endmodule
